// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Cycles from start-bit edge to end of the last stop bit.
  function automatic int frame_cycles(int clkdiv, int data_bits, int parity, int stop_bits);
    return clkdiv * (1 + data_bits + ((parity != int'(PAR_NONE)) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with combinational read of the head entry; push when full and
// pop when empty are ignored. A pop never frees a slot for a push in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push  = push && (level_q != FULL_LEVEL);
    do_pop   = pop && (level_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter: configurable data width, parity and stop bits; frames
// are sent back to back while the FIFO holds data. tx_pin lags the FSM by one cycle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKDIV     = 128,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  if (CLKDIV < 2) begin : g_bad_clkdiv
    $error("uart_tx_fifo: CLKDIV must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  localparam int BAUD_W = $clog2(CLKDIV);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST   = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST   = BIT_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0]  FULL_LEVEL  = LVL_W'(FIFO_DEPTH);
  localparam bit                HAS_PARITY  = (PARITY != int'(PAR_NONE));
  localparam bit                PAR_IS_EVEN = (PARITY == int'(PAR_EVEN));

  tx_state_e              state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_pin_q, tx_pin_d;
  logic                   push;
  logic                   pop;
  logic                   load;
  logic                   baud_done;
  logic                   fifo_has_data;
  logic [DATA_BITS-1:0]   pop_data;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .level     (fifo_level)
  );

  assign s_ready       = (fifo_level != FULL_LEVEL);
  assign push          = s_valid && s_ready;
  assign fifo_has_data = (fifo_level != '0);
  assign baud_done     = (baud_q == '0);
  assign tx_busy       = (state_q != ST_IDLE) || fifo_has_data;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    load    = 1'b0;
    if ((state_q != ST_IDLE) && !baud_done) begin
      baud_d = baud_q - 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        load = fifo_has_data;
      end
      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
          baud_d  = BAUD_LAST;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d  = BAUD_LAST;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          baud_d  = BAUD_LAST;
          bit_d   = '0;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d = BAUD_LAST;
          if (bit_q == STOP_LAST) begin
            state_d = ST_IDLE;
            load    = fifo_has_data;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Loading straight from the last stop cycle gives a zero-gap next start bit.
    if (load) begin
      state_d = ST_START;
      baud_d  = BAUD_LAST;
      bit_d   = '0;
      shift_d = pop_data;
      par_d   = PAR_IS_EVEN ? ^pop_data : ~^pop_data;
    end
    pop = load;
  end

  always_comb begin
    case (state_q)
      ST_START:  tx_pin_d = 1'b0;
      ST_DATA:   tx_pin_d = shift_q[0];
      ST_PARITY: tx_pin_d = par_q;
      default:   tx_pin_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_pin_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_pin_q <= tx_pin_d;
    end
  end

  assign tx_pin = tx_pin_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations checked every cycle against a
// timeline model of frames, plus table vectors and directed corner sequences.
module tb_uart_tx_fifo;

  typedef struct {
    int         inst;
    int         t;
    int         ps;
    logic [8:0] data;
  } frame_t;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       exp_par;
    int         exp_frame;
  } par_vec_t;

  logic       clk = 1'b0;
  logic       rst_r   [4];
  logic       sval    [4];
  logic [8:0] sdat    [4];
  logic       ready_w [4];
  logic       pin_w   [4];
  logic       busy_w  [4];
  logic [2:0] lvl_w   [4];

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  bit     chk_en = 1'b0;
  int     last_end [4];
  int     ps_last  [4];
  int     t_last   [4];
  int     acc_cnt  [4];
  frame_t frames [$];
  frame_t nf;

  par_vec_t pv [6];
  logic     exp_a5 [10];
  logic     exp_41 [10];
  logic [8:0] words [6];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKDIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst_r[0]), .s_data(sdat[0][7:0]), .s_valid(sval[0]), .s_ready(ready_w[0]),
    .tx_pin(pin_w[0]), .tx_busy(busy_w[0]), .fifo_level(lvl_w[0]));
  uart_tx_fifo #(.CLKDIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst_r[1]), .s_data(sdat[1][7:0]), .s_valid(sval[1]), .s_ready(ready_w[1]),
    .tx_pin(pin_w[1]), .tx_busy(busy_w[1]), .fifo_level(lvl_w[1]));
  uart_tx_fifo #(.CLKDIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst_r[2]), .s_data(sdat[2][7:0]), .s_valid(sval[2]), .s_ready(ready_w[2]),
    .tx_pin(pin_w[2]), .tx_busy(busy_w[2]), .fifo_level(lvl_w[2]));
  uart_tx_fifo #(.CLKDIV(3), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst_r[3]), .s_data(sdat[3][6:0]), .s_valid(sval[3]), .s_ready(ready_w[3]),
    .tx_pin(pin_w[3]), .tx_busy(busy_w[3]), .fifo_level(lvl_w[3]));

  function automatic int cfg_cd(int i);
    case (i)
      0: return 16;
      3: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_db(int i);
    return (i == 3) ? 7 : 8;
  endfunction

  function automatic int cfg_par(int i);
    case (i)
      1: return 2;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_stop(int i);
    return (i == 1 || i == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(int i);
    return cfg_cd(i) * (1 + cfg_db(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stop(i));
  endfunction

  function automatic logic par_bit(int i, logic [8:0] d);
    int ones;
    ones = $countones(d);
    return (cfg_par(i) == 2) ? ((ones % 2) == 1) : ((ones % 2) == 0);
  endfunction

  // Entries still waiting in the FIFO after edge e: accepted, not yet popped (pop at ps-1).
  function automatic int exp_level(int i, int e);
    int n;
    n = 0;
    foreach (frames[k]) begin
      if (frames[k].inst == i && frames[k].t <= e && e < frames[k].ps - 1) n++;
    end
    return n;
  endfunction

  function automatic logic exp_busy(int i, int e);
    foreach (frames[k]) begin
      if (frames[k].inst == i && frames[k].t <= e && e <= frames[k].ps + frame_len(i) - 2) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic exp_pin(int i, int e);
    int slot;
    foreach (frames[k]) begin
      if (frames[k].inst == i && e >= frames[k].ps && e < frames[k].ps + frame_len(i)) begin
        slot = (e - frames[k].ps) / cfg_cd(i);
        if (slot == 0) return 1'b0;
        if (slot <= cfg_db(i)) return frames[k].data[slot-1];
        if (cfg_par(i) != 0 && slot == cfg_db(i) + 1) return par_bit(i, frames[k].data);
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  task automatic chk(string name, int inst, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d: got %0d, expected %0d", name, inst, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic push_one(int i, logic [8:0] d);
    int base;
    base = acc_cnt[i];
    @(negedge clk);
    sval[i] = 1'b1;
    sdat[i] = d;
    for (int n = 0; n < 2000 && acc_cnt[i] == base; n++) @(negedge clk);
    sval[i] = 1'b0;
    chk("push_accepted", i, acc_cnt[i] - base, 1);
  endtask

  // Reference model: each accepted word becomes a frame whose first line cycle is
  // two edges after acceptance, or immediately after the previous frame if later.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (rst_r[i]) begin
          for (int k = frames.size() - 1; k >= 0; k--) begin
            if (frames[k].inst == i) frames.delete(k);
          end
          last_end[i] = 0;
        end else if (sval[i] && exp_level(i, cyc - 1) != 4) begin
          nf.inst = i;
          nf.t    = cyc;
          nf.ps   = (cyc + 2 > last_end[i]) ? cyc + 2 : last_end[i];
          nf.data = sdat[i] & 9'((1 << cfg_db(i)) - 1);
          frames.push_back(nf);
          last_end[i] = nf.ps + frame_len(i);
          ps_last[i]  = nf.ps;
          t_last[i]   = cyc;
          acc_cnt[i]++;
          $display("push inst=%0d cyc=%0d data=0x%0h line_start=%0d", i, cyc, nf.data, nf.ps);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 4; i++) begin
          chk("mon_pin", i, int'(pin_w[i]), int'(exp_pin(i, cyc)));
          chk("mon_busy", i, int'(busy_w[i]), int'(exp_busy(i, cyc)));
          chk("mon_level", i, int'(lvl_w[i]), exp_level(i, cyc));
          chk("mon_ready", i, int'(ready_w[i]), (exp_level(i, cyc) != 4) ? 1 : 0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, ps0, k, iv, max_end, lows;
    bit seen_full;

    pv[0] = '{1, 9'h007, 1'b1, 48};
    pv[1] = '{1, 9'h003, 1'b0, 48};
    pv[2] = '{1, 9'h0FF, 1'b0, 48};
    pv[3] = '{2, 9'h000, 1'b1, 44};
    pv[4] = '{2, 9'h0FF, 1'b1, 44};
    pv[5] = '{2, 9'h001, 1'b0, 44};
    exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_41 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    words  = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};

    for (int i = 0; i < 4; i++) begin
      rst_r[i] = 1'b1; sval[i] = 1'b0; sdat[i] = '0;
      last_end[i] = 0; ps_last[i] = 0; t_last[i] = 0; acc_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) rst_r[i] = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_pin", i, int'(pin_w[i]), 1);
      chk("rst_busy", i, int'(busy_w[i]), 0);
      chk("rst_level", i, int'(lvl_w[i]), 0);
      chk("rst_ready", i, int'(ready_w[i]), 1);
    end

    // 8N1 frame of 0xA5: start two edges after acceptance, then LSB-first bits.
    push_one(0, 9'h0A5);
    t0 = t_last[0];
    wait_cyc(t0 + 1);
    chk("a5_pin_before_start", 0, int'(pin_w[0]), 1);
    wait_cyc(t0 + 2);
    chk("a5_start_latency", 0, int'(pin_w[0]), 0);
    for (int b = 0; b < 10; b++) begin
      wait_cyc(t0 + 2 + 16 * b + 8);
      chk("a5_slot", 0, int'(pin_w[0]), int'(exp_a5[b]));
    end
    wait_cyc(t0 + 160);
    chk("a5_busy_last", 0, int'(busy_w[0]), 1);
    wait_cyc(t0 + 161);
    chk("a5_busy_fall", 0, int'(busy_w[0]), 0);

    // Parity table: parity slot value and total frame length.
    for (int v = 0; v < 6; v++) begin
      iv = pv[v].inst;
      push_one(iv, pv[v].data);
      ps0 = ps_last[iv];
      wait_cyc(ps0 + 9 * 4 + 2);
      chk("parity_bit", iv, int'(pin_w[iv]), int'(pv[v].exp_par));
      wait_cyc(ps0 + pv[v].exp_frame - 2);
      chk("frame_busy_end", iv, int'(busy_w[iv]), 1);
      wait_cyc(ps0 + pv[v].exp_frame - 1);
      chk("frame_busy_fall", iv, int'(busy_w[iv]), 0);
    end

    // 7 data bits, 2 stop bits.
    push_one(3, 9'h041);
    ps0 = ps_last[3];
    for (int b = 0; b < 10; b++) begin
      wait_cyc(ps0 + 3 * b + 1);
      chk("d7_slot", 3, int'(pin_w[3]), int'(exp_41[b]));
    end
    wait_cyc(ps0 + 28);
    chk("d7_busy_end", 3, int'(busy_w[3]), 1);
    wait_cyc(ps0 + 29);
    chk("d7_busy_fall", 3, int'(busy_w[3]), 0);

    // s_valid held with 6 words: 5 accepted, then s_ready low until the first pop.
    iv = acc_cnt[0];
    seen_full = 1'b0;
    ps0 = -100000;
    for (int n = 0; n < 3000 && acc_cnt[0] - iv < 6; n++) begin
      k = acc_cnt[0] - iv;
      sval[0] = 1'b1;
      sdat[0] = words[k];
      @(negedge clk);
      k = acc_cnt[0] - iv;
      if (k >= 1 && ps0 < 0) ps0 = frames[frames.size() - 1].ps;
      if (k == 5 && !seen_full) begin
        seen_full = 1'b1;
        chk("burst_full_level", 0, int'(lvl_w[0]), 4);
        chk("burst_full_ready", 0, int'(ready_w[0]), 0);
      end
      if (cyc == ps0 + 158) chk("burst_ready_held", 0, int'(ready_w[0]), 0);
      if (cyc == ps0 + 159) chk("burst_ready_after_pop", 0, int'(ready_w[0]), 1);
    end
    sval[0] = 1'b0;
    chk("burst_accepted", 0, acc_cnt[0] - iv, 6);
    wait_cyc(ps0 + 6 * 160 - 2);
    chk("burst_busy_end", 0, int'(busy_w[0]), 1);
    wait_cyc(ps0 + 6 * 160 - 1);
    chk("burst_busy_fall", 0, int'(busy_w[0]), 0);

    // Reset mid-DATA with two words queued.
    iv = acc_cnt[0];
    for (int n = 0; n < 100 && acc_cnt[0] - iv < 3; n++) begin
      sval[0] = 1'b1;
      sdat[0] = 9'h0C3 + 9'(acc_cnt[0] - iv);
      @(negedge clk);
    end
    sval[0] = 1'b0;
    ps0 = ps_last[0] - 2 * 0;
    ps0 = frames[frames.size() - 3].ps;
    wait_cyc(ps0 + 16 * 3 + 5);
    chk("pre_rst_level", 0, int'(lvl_w[0]), 2);
    rst_r[0] = 1'b1;
    @(negedge clk);
    rst_r[0] = 1'b0;
    chk("rst_mid_pin", 0, int'(pin_w[0]), 1);
    chk("rst_mid_level", 0, int'(lvl_w[0]), 0);
    chk("rst_mid_ready", 0, int'(ready_w[0]), 1);
    chk("rst_mid_busy", 0, int'(busy_w[0]), 0);
    lows = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!pin_w[0]) lows++;
    end
    chk("no_frame_after_rst", 0, lows, 0);

    // Random traffic on all instances, with one reset in the middle on instance 2.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst_r[2] = (n == 200);
      for (int i = 0; i < 4; i++) begin
        sval[i] = ($urandom_range(0, 7) == 0);
        sdat[i] = 9'($urandom_range(0, 511));
      end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) sval[i] = 1'b0;
    rst_r[2] = 1'b0;
    max_end = 0;
    for (int i = 0; i < 4; i++) if (last_end[i] > max_end) max_end = last_end[i];
    wait_cyc(max_end + 2);
    for (int i = 0; i < 4; i++) begin
      chk("drain_busy", i, int'(busy_w[i]), 0);
      chk("drain_pin", i, int'(pin_w[i]), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
